dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
- Buffered, parametrised dispatch stage between the decoder and the Tomasulo back end (ROB, reservation station, load/store buffer).
- Holds up to DEPTH decoded instructions in a FIFO and issues at most one per cycle from the head.
- At issue it resolves operands from the register file, the ROB and CDB_N same-cycle CDB channels, renames rd, and routes the instruction to the RS or the LSB.
- Applies back-pressure to the decoder and empties on flush.

Parameters:
XLEN, 32, data/address width
ROB_W, 4, ROB tag width
TYPE_W, 6, instruction-type code width
DEPTH, 4, queue entries (power of two, >=2)
CDB_N, 2, number of snooped CDB channels

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; 0 = hold all state
flush_in  in  1  mispredict flush
dec_valid_in  in  1  decoder offers instruction
dec_ready_out  out  1  queue accepts instruction
dec_type_in  in  TYPE_W  instruction type
dec_is_mem_in  in  1  1 = load/store (routes to LSB)
dec_rs1_in / dec_rs2_in / dec_rd_in  in  5 each  register indices
dec_imm_in  in  XLEN  immediate
dec_pc_in  in  XLEN  instruction PC
reg_rs1_out / reg_rs2_out  out  5 each  regfile query indices (head entry)
reg_rs1_data_in / reg_rs2_data_in  in  XLEN each  regfile values
reg_rs1_busy_in / reg_rs2_busy_in  in  1 each  register renamed
reg_rs1_tag_in / reg_rs2_tag_in  in  ROB_W each  producer ROB tag
reg_rename_en_out  out  1  write rename tag for rd
reg_rd_out  out  5  register to rename
reg_rd_tag_out  out  ROB_W  new tag (= rob_free_tag_in)
rob_full_in  in  1  ROB cannot accept
rob_free_tag_in  in  ROB_W  tag of next free ROB entry
rob_q1_tag_out / rob_q2_tag_out  out  ROB_W each  ROB readiness query
rob_q1_rdy_in / rob_q2_rdy_in  in  1 each  queried entry has a result
rob_q1_data_in / rob_q2_data_in  in  XLEN each  queried result
rob_en_out  out  1  allocate ROB entry
cdb_valid_in  in  CDB_N  per-channel broadcast valid
cdb_tag_in  in  CDB_N*ROB_W  packed broadcast tags
cdb_data_in  in  CDB_N*XLEN  packed broadcast data
rs_full_in / lsb_full_in  in  1 each  target full
rs_en_out / lsb_en_out  out  1 each  issue strobe to RS / LSB
vj_out / vk_out  out  XLEN each  operand values
qj_out / qk_out  out  ROB_W each  pending producer tags
qj_valid_out / qk_valid_out  out  1 each  1 = operand still pending
type_out  out  TYPE_W  instruction type
rd_out  out  5  destination register (to ROB)
imm_out / pc_out  out  XLEN each  immediate, PC
dest_out  out  ROB_W  allocated ROB tag

Behaviour:
- Clocking: single clock clk_in; rst_in is synchronous and active-high. Reset and flush both clear the pointers and the count to 0.
- Reset: all *_en_out and dec_ready_out are 0. Payload outputs are don't-care while no enable is asserted.
- Queue: circular buffer with head/tail pointers (log2 DEPTH bits, natural wrap) and a count of (log2 DEPTH)+1 bits. dec_ready_out = (count != DEPTH) && !rst_in && rdy_in; it is registered-state-only and independent of issue this cycle.
- Push: occurs on a rising edge with dec_valid_in && dec_ready_out && !flush_in.
- Issue condition (combinational, same cycle): count != 0 && rdy_in && !flush_in && !rob_full_in && (dec_is_mem ? !lsb_full_in : !rs_full_in) for the head entry.
- On issue: rob_en_out = 1; exactly one of rs_en_out/lsb_en_out = 1; reg_rename_en_out = (rd != 0). The head pointer advances at the edge.
- Latency: an instruction always spends at least one cycle in the queue; there is no decoder-to-output bypass. A push at edge N allows issue in cycle N+1.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Full queue: push is refused even if issuing that cycle. Empty queue: no enables.
- Operand resolution, applied per source with first match winning:
  - (a) index 0: value 0, not pending;
  - (b) !busy: regfile data;
  - (c) busy and a valid CDB channel tag equals the register tag: that channel's data, lowest channel index first;
  - (d) busy and ROB rdy: ROB data;
  - (e) otherwise: vX = 0, qX = tag, qX_valid = 1.
- rob_qN_tag_out is always driven with reg_rsN_tag_in.
- Back-to-back dependency: the rename written at issue edge N is visible in the regfile at cycle N+1. No internal forwarding is required.
- dest_out = reg_rd_tag_out = rob_free_tag_in.
- Flush: takes priority over push and issue in the same cycle; all enables are 0 during the flush cycle.
- rdy_in = 0: no pointer/count/storage update and all enables 0, regardless of other inputs.

Test Plan:
- Reset, then push 4 instructions with rs_full_in=1 -> dec_ready_out falls to 0 after the 4th push; no issue; a 5th offer is refused; release rs_full -> one issue per cycle, in order.
- Head `addi x5,x1,7` with x1 not busy and data 0x10 -> rs_en_out=1, vj=0x10, qj_valid=0, imm=7, reg_rename_en=1, reg_rd=5, dest=rob_free_tag_in=3.
- x1 busy with tag 6 and cdb_valid[1]=1, tag 6, data 0xAB in the same cycle -> vj=0xAB, qj_valid=0; with no CDB match and rob_q1_rdy=0 -> qj=6, qj_valid=1.
- Load with lsb_full_in=1 and rs_full_in=0 -> no issue and no enables; lsb_full drops -> lsb_en_out=1, rs_en_out=0.
- rs1=x0 and rd=x0, with regfile reporting busy -> vj=0, qj_valid=0, reg_rename_en=0, rob_en=1.
- Queue holds 3 entries, flush_in=1 with dec_valid_in=1 -> next cycle count=0, no enables, the pushed instruction is discarded; rdy_in=0 mid-stream -> state frozen, then resumes unchanged.

Source files
------------

// File: rtl/dispatch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_queue_if
// Description : Decoder-to-dispatch handshake bundle. The decoder (master)
//               offers one decoded instruction per cycle with dec_valid_in.
//               The dispatch queue (slave) accepts it with dec_ready_out.
//               Signal names carry the dispatch-queue-side direction suffix.
// Ports       : dec_valid_in/dec_ready_out handshake; dec_type_in,
//               dec_is_mem_in, dec_rs1_in, dec_rs2_in, dec_rd_in, dec_imm_in,
//               dec_pc_in payload.
// Revision    : 1.0 - initial release
// ============================================================================
interface dispatch_queue_if #(
    parameter int XLEN   = 32,
    parameter int TYPE_W = 6
);
    logic              dec_valid_in;
    logic              dec_ready_out;
    logic [TYPE_W-1:0] dec_type_in;
    logic              dec_is_mem_in;
    logic [4:0]        dec_rs1_in;
    logic [4:0]        dec_rs2_in;
    logic [4:0]        dec_rd_in;
    logic [XLEN-1:0]   dec_imm_in;
    logic [XLEN-1:0]   dec_pc_in;

    modport master (
        output dec_valid_in, dec_type_in, dec_is_mem_in,
               dec_rs1_in, dec_rs2_in, dec_rd_in, dec_imm_in, dec_pc_in,
        input  dec_ready_out
    );

    modport slave (
        input  dec_valid_in, dec_type_in, dec_is_mem_in,
               dec_rs1_in, dec_rs2_in, dec_rd_in, dec_imm_in, dec_pc_in,
        output dec_ready_out
    );
endinterface
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_queue
// Description : DEPTH-entry FIFO between decoder and Tomasulo back end. Issues
//               at most one instruction per cycle from the head, resolving its
//               source operands from regfile / CDB / ROB, renaming rd, and
//               routing to the reservation station or load/store buffer.
// Ports       : clk_in, rst_in, rdy_in, flush_in; dec (decoder handshake);
//               reg_* regfile query/rename; rob_* ROB query/allocate;
//               cdb_* snooped broadcast channels; rs_/lsb_ full+enable;
//               issue payload vj/vk/qj/qk/type/rd/imm/pc/dest.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_queue #(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 4,
    parameter int TYPE_W = 6,
    parameter int DEPTH  = 4,
    parameter int CDB_N  = 2
) (
    input  wire logic                    clk_in,
    input  wire logic                    rst_in,
    input  wire logic                    rdy_in,
    input  wire logic                    flush_in,
    dispatch_queue_if.slave              dec,
    output logic [4:0]                   reg_rs1_out,
    output logic [4:0]                   reg_rs2_out,
    input  wire logic [XLEN-1:0]         reg_rs1_data_in,
    input  wire logic [XLEN-1:0]         reg_rs2_data_in,
    input  wire logic                    reg_rs1_busy_in,
    input  wire logic                    reg_rs2_busy_in,
    input  wire logic [ROB_W-1:0]        reg_rs1_tag_in,
    input  wire logic [ROB_W-1:0]        reg_rs2_tag_in,
    output logic                         reg_rename_en_out,
    output logic [4:0]                   reg_rd_out,
    output logic [ROB_W-1:0]             reg_rd_tag_out,
    input  wire logic                    rob_full_in,
    input  wire logic [ROB_W-1:0]        rob_free_tag_in,
    output logic [ROB_W-1:0]             rob_q1_tag_out,
    output logic [ROB_W-1:0]             rob_q2_tag_out,
    input  wire logic                    rob_q1_rdy_in,
    input  wire logic                    rob_q2_rdy_in,
    input  wire logic [XLEN-1:0]         rob_q1_data_in,
    input  wire logic [XLEN-1:0]         rob_q2_data_in,
    output logic                         rob_en_out,
    input  wire logic [CDB_N-1:0]        cdb_valid_in,
    input  wire logic [CDB_N*ROB_W-1:0]  cdb_tag_in,
    input  wire logic [CDB_N*XLEN-1:0]   cdb_data_in,
    input  wire logic                    rs_full_in,
    input  wire logic                    lsb_full_in,
    output logic                         rs_en_out,
    output logic                         lsb_en_out,
    output logic [XLEN-1:0]              vj_out,
    output logic [XLEN-1:0]              vk_out,
    output logic [ROB_W-1:0]             qj_out,
    output logic [ROB_W-1:0]             qk_out,
    output logic                         qj_valid_out,
    output logic                         qk_valid_out,
    output logic [TYPE_W-1:0]            type_out,
    output logic [4:0]                   rd_out,
    output logic [XLEN-1:0]              imm_out,
    output logic [XLEN-1:0]              pc_out,
    output logic [ROB_W-1:0]             dest_out
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]  v;
        logic [ROB_W-1:0] q;
        logic             pend;
    } opnd_t;

    // Queue storage (no reset needed: only entries below count are ever read
    // as valid).
    logic [TYPE_W-1:0] type_q [DEPTH];
    logic              mem_q  [DEPTH];
    logic [4:0]        rs1_q  [DEPTH];
    logic [4:0]        rs2_q  [DEPTH];
    logic [4:0]        rd_q   [DEPTH];
    logic [XLEN-1:0]   imm_q  [DEPTH];
    logic [XLEN-1:0]   pc_q   [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic  w_push;
    logic  w_issue;
    logic  w_head_mem;
    opnd_t w_op1;
    opnd_t w_op2;

    // Operand source priority: x0, idle register, CDB (lowest channel wins),
    // completed ROB entry, otherwise wait on the producer tag.
    function automatic opnd_t resolve(
        input logic [4:0]             idx,
        input logic                   busy,
        input logic [ROB_W-1:0]       tag,
        input logic [XLEN-1:0]        rf_data,
        input logic                   rob_rdy,
        input logic [XLEN-1:0]        rob_data,
        input logic [CDB_N-1:0]       cv,
        input logic [CDB_N*ROB_W-1:0] ct,
        input logic [CDB_N*XLEN-1:0]  cd
    );
        opnd_t r;
        logic  hit;
        r   = '0;
        hit = 1'b0;
        if (idx == 5'd0) begin
            r = '0;
        end else if (!busy) begin
            r.v = rf_data;
        end else begin
            // Scan downward so the lowest matching channel is the last write.
            for (int c = CDB_N - 1; c >= 0; c--) begin
                if (cv[c] && (ct[c*ROB_W +: ROB_W] == tag)) begin
                    hit = 1'b1;
                    r.v = cd[c*XLEN +: XLEN];
                end
            end
            if (!hit) begin
                if (rob_rdy) begin
                    r.v = rob_data;
                end else begin
                    r.q    = tag;
                    r.pend = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Ready depends only on registered occupancy, never on this cycle's issue.
    assign dec.dec_ready_out = (count_q != FULL_CNT) && !rst_in && rdy_in;
    assign w_push            = dec.dec_valid_in && dec.dec_ready_out && !flush_in;

    assign w_head_mem = mem_q[head_q];
    assign w_issue    = (count_q != '0) && rdy_in && !rst_in && !flush_in && !rob_full_in &&
                        (w_head_mem ? !lsb_full_in : !rs_full_in);

    assign reg_rs1_out    = rs1_q[head_q];
    assign reg_rs2_out    = rs2_q[head_q];
    assign rob_q1_tag_out = reg_rs1_tag_in;
    assign rob_q2_tag_out = reg_rs2_tag_in;

    assign w_op1 = resolve(rs1_q[head_q], reg_rs1_busy_in, reg_rs1_tag_in, reg_rs1_data_in,
                           rob_q1_rdy_in, rob_q1_data_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
    assign w_op2 = resolve(rs2_q[head_q], reg_rs2_busy_in, reg_rs2_tag_in, reg_rs2_data_in,
                           rob_q2_rdy_in, rob_q2_data_in, cdb_valid_in, cdb_tag_in, cdb_data_in);

    assign rob_en_out        = w_issue;
    assign rs_en_out         = w_issue && !w_head_mem;
    assign lsb_en_out        = w_issue && w_head_mem;
    assign reg_rename_en_out = w_issue && (rd_q[head_q] != 5'd0);
    assign reg_rd_out        = rd_q[head_q];
    assign reg_rd_tag_out    = rob_free_tag_in;
    assign dest_out          = rob_free_tag_in;

    assign vj_out       = w_op1.v;
    assign qj_out       = w_op1.q;
    assign qj_valid_out = w_op1.pend;
    assign vk_out       = w_op2.v;
    assign qk_out       = w_op2.q;
    assign qk_valid_out = w_op2.pend;
    assign type_out     = type_q[head_q];
    assign rd_out       = rd_q[head_q];
    assign imm_out      = imm_q[head_q];
    assign pc_out       = pc_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_issue) head_d = head_q + 1'b1;
            if (w_push)  tail_d = tail_q + 1'b1;
            case ({w_push, w_issue})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            type_q[tail_q] <= dec.dec_type_in;
            mem_q[tail_q]  <= dec.dec_is_mem_in;
            rs1_q[tail_q]  <= dec.dec_rs1_in;
            rs2_q[tail_q]  <= dec.dec_rs2_in;
            rd_q[tail_q]   <= dec.dec_rd_in;
            imm_q[tail_q]  <= dec.dec_imm_in;
            pc_q[tail_q]   <= dec.dec_pc_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_queue
// Description : Self-checking bench for dispatch_queue. A driver applies
//               directed scenarios followed by random traffic; an independent
//               monitor keeps a queue-based reference model and compares every
//               cycle's handshake, enables and issued payload.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue;
    localparam int XLEN = 32, ROB_W = 4, TYPE_W = 6, DEPTH = 4, CDB_N = 2;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic              mem;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } entry_t;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic rs1_busy, rs2_busy;
    logic [ROB_W-1:0] rs1_tag, rs2_tag;
    logic rob_full;
    logic [ROB_W-1:0] rob_free_tag;
    logic rob_q1_rdy, rob_q2_rdy;
    logic [XLEN-1:0] rob_q1_data, rob_q2_data;
    logic [CDB_N-1:0] cdb_valid;
    logic [CDB_N*ROB_W-1:0] cdb_tag;
    logic [CDB_N*XLEN-1:0] cdb_data;
    logic rs_full, lsb_full;

    logic [4:0] reg_rs1, reg_rs2, reg_rd;
    logic rename_en, rob_en, rs_en, lsb_en;
    logic [ROB_W-1:0] rd_tag, q1_tag, q2_tag, qj, qk, dest;
    logic [XLEN-1:0] vj, vk, imm_o, pc_o;
    logic qj_v, qk_v;
    logic [TYPE_W-1:0] type_o;
    logic [4:0] rd_o;

    int n_chk = 0;
    int n_err = 0;

    dispatch_queue_if #(.XLEN(XLEN), .TYPE_W(TYPE_W)) dif ();

    dispatch_queue #(.XLEN(XLEN), .ROB_W(ROB_W), .TYPE_W(TYPE_W), .DEPTH(DEPTH), .CDB_N(CDB_N)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush), .dec(dif),
        .reg_rs1_out(reg_rs1), .reg_rs2_out(reg_rs2),
        .reg_rs1_data_in(rs1_data), .reg_rs2_data_in(rs2_data),
        .reg_rs1_busy_in(rs1_busy), .reg_rs2_busy_in(rs2_busy),
        .reg_rs1_tag_in(rs1_tag), .reg_rs2_tag_in(rs2_tag),
        .reg_rename_en_out(rename_en), .reg_rd_out(reg_rd), .reg_rd_tag_out(rd_tag),
        .rob_full_in(rob_full), .rob_free_tag_in(rob_free_tag),
        .rob_q1_tag_out(q1_tag), .rob_q2_tag_out(q2_tag),
        .rob_q1_rdy_in(rob_q1_rdy), .rob_q2_rdy_in(rob_q2_rdy),
        .rob_q1_data_in(rob_q1_data), .rob_q2_data_in(rob_q2_data),
        .rob_en_out(rob_en), .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_data_in(cdb_data),
        .rs_full_in(rs_full), .lsb_full_in(lsb_full), .rs_en_out(rs_en), .lsb_en_out(lsb_en),
        .vj_out(vj), .vk_out(vk), .qj_out(qj), .qk_out(qk),
        .qj_valid_out(qj_v), .qk_valid_out(qk_v), .type_out(type_o), .rd_out(rd_o),
        .imm_out(imm_o), .pc_out(pc_o), .dest_out(dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference operand lookup, straight from the source-priority rules.
    function automatic void ref_operand(input logic [4:0] idx, input logic busy,
                                        input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] rf,
                                        input logic rrdy, input logic [XLEN-1:0] rdat,
                                        output logic [XLEN-1:0] v, output logic pend);
        v = '0; pend = 1'b0;
        if (idx == 0) return;
        if (!busy) begin v = rf; return; end
        for (int c = 0; c < CDB_N; c++)
            if (cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == tag) begin
                v = cdb_data[c*XLEN +: XLEN];
                return;
            end
        if (rrdy) v = rdat;
        else pend = 1'b1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    entry_t mq[$];

    always @(negedge clk) begin : mon
        entry_t h, n;
        logic e_rdy, e_iss;
        logic [XLEN-1:0] ev;
        logic ep;
        h = (mq.size() != 0) ? mq[0] : '0;
        e_rdy = !rst && rdy && (mq.size() != DEPTH);
        e_iss = !rst && rdy && !flush && (mq.size() != 0) && !rob_full &&
                (h.mem ? !lsb_full : !rs_full);
        chk("dec_ready", dif.dec_ready_out, e_rdy);
        chk("rob_en", rob_en, e_iss);
        chk("rs_en", rs_en, e_iss && !h.mem);
        chk("lsb_en", lsb_en, e_iss && h.mem);
        chk("rename_en", rename_en, e_iss && (h.rd != 0));
        chk("rob_q1_tag", q1_tag, rs1_tag);
        chk("rob_q2_tag", q2_tag, rs2_tag);
        if (mq.size() != 0 && !rst) begin
            chk("reg_rs1", reg_rs1, h.rs1);
            chk("reg_rs2", reg_rs2, h.rs2);
        end
        if (e_iss) begin
            ref_operand(h.rs1, rs1_busy, rs1_tag, rs1_data, rob_q1_rdy, rob_q1_data, ev, ep);
            chk("qj_valid", qj_v, ep);
            if (ep) chk("qj", qj, rs1_tag); else chk("vj", vj, ev);
            ref_operand(h.rs2, rs2_busy, rs2_tag, rs2_data, rob_q2_rdy, rob_q2_data, ev, ep);
            chk("qk_valid", qk_v, ep);
            if (ep) chk("qk", qk, rs2_tag); else chk("vk", vk, ev);
            chk("type", type_o, h.typ);
            chk("rd", rd_o, h.rd);
            chk("reg_rd", reg_rd, h.rd);
            chk("imm", imm_o, h.imm);
            chk("pc", pc_o, h.pc);
            chk("dest", dest, rob_free_tag);
            chk("rd_tag", rd_tag, rob_free_tag);
        end
        // advance model to the state after the coming edge
        if (rst) mq.delete();
        else if (rdy) begin
            if (flush) mq.delete();
            else begin
                if (e_iss) void'(mq.pop_front());
                if (dif.dec_valid_in && e_rdy) begin
                    n.typ = dif.dec_type_in; n.mem = dif.dec_is_mem_in;
                    n.rs1 = dif.dec_rs1_in;  n.rs2 = dif.dec_rs2_in; n.rd = dif.dec_rd_in;
                    n.imm = dif.dec_imm_in;  n.pc  = dif.dec_pc_in;
                    mq.push_back(n);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        dif.dec_valid_in = 1'b0; dif.dec_type_in = '0; dif.dec_is_mem_in = 1'b0;
        dif.dec_rs1_in = '0; dif.dec_rs2_in = '0; dif.dec_rd_in = '0;
        dif.dec_imm_in = '0; dif.dec_pc_in = '0;
        rs1_data = '0; rs2_data = '0; rs1_busy = 1'b0; rs2_busy = 1'b0;
        rs1_tag = '0; rs2_tag = '0; rob_full = 1'b0; rob_free_tag = 4'd3;
        rob_q1_rdy = 1'b0; rob_q2_rdy = 1'b0; rob_q1_data = '0; rob_q2_data = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; rs_full = 1'b0; lsb_full = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic offer(input logic [TYPE_W-1:0] t, input logic m, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic [XLEN-1:0] im);
        dif.dec_valid_in = 1'b1; dif.dec_type_in = t; dif.dec_is_mem_in = m;
        dif.dec_rs1_in = a; dif.dec_rs2_in = b; dif.dec_rd_in = d;
        dif.dec_imm_in = im; dif.dec_pc_in = dif.dec_pc_in + 32'd4;
    endtask

    initial begin
        idle(); rst = 1'b1;
        tick(3);
        rst = 1'b0;
        // fill with RS blocked; 5th and 6th offers refused, then drain in order
        rs_full = 1'b1;
        for (int i = 0; i < 6; i++) begin offer(6'(i + 1), 1'b0, 5'd1, 5'd2, 5'(i + 1), 32'(i)); tick(1); end
        dif.dec_valid_in = 1'b0; rs_full = 1'b0; rs1_data = 32'h55; rs2_data = 32'h66;
        tick(6);
        // addi x5,x1,7 with x1 idle, data 0x10
        offer(6'd3, 1'b0, 5'd1, 5'd0, 5'd5, 32'd7); tick(1);
        dif.dec_valid_in = 1'b0; rs1_data = 32'h10; rob_free_tag = 4'd3; tick(1);
        // x1 busy tag 6, CDB channel 1 broadcasts it
        offer(6'd4, 1'b0, 5'd1, 5'd2, 5'd6, 32'd1); tick(1);
        offer(6'd4, 1'b0, 5'd1, 5'd2, 5'd7, 32'd2);
        rs1_busy = 1'b1; rs1_tag = 4'd6; cdb_valid = 2'b10;
        cdb_tag = {4'd6, 4'd2}; cdb_data = {32'hAB, 32'h11}; tick(1);
        // no CDB match, ROB not ready -> pending on tag 6
        dif.dec_valid_in = 1'b0; cdb_valid = 2'b00; tick(1);
        rs1_busy = 1'b0;
        // load blocked by LSB, then released
        offer(6'd9, 1'b1, 5'd2, 5'd0, 5'd8, 32'h40); lsb_full = 1'b1; tick(1);
        dif.dec_valid_in = 1'b0; tick(2);
        lsb_full = 1'b0; tick(1);
        // x0 sources / destination with busy regfile
        offer(6'd5, 1'b0, 5'd0, 5'd0, 5'd0, 32'd9); tick(1);
        dif.dec_valid_in = 1'b0; rs1_busy = 1'b1; rs2_busy = 1'b1; tick(1);
        rs1_busy = 1'b0; rs2_busy = 1'b0;
        // three queued, flush with a concurrent offer
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin offer(6'd7, 1'b0, 5'd3, 5'd4, 5'd9, 32'(i)); tick(1); end
        flush = 1'b1; tick(1);
        flush = 1'b0; dif.dec_valid_in = 1'b0; rs_full = 1'b0; tick(3);
        // freeze with rdy low mid-stream
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin offer(6'd8, 1'b0, 5'd5, 5'd6, 5'd10, 32'(i)); tick(1); end
        rs_full = 1'b0; rdy = 1'b0; tick(3);
        rdy = 1'b1; dif.dec_valid_in = 1'b0; tick(4);
        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom % 300) == 0;
            rdy = ($urandom % 12) != 0;
            flush = ($urandom % 40) == 0;
            dif.dec_valid_in = ($urandom % 3) != 0;
            dif.dec_type_in = 6'($urandom); dif.dec_is_mem_in = 1'($urandom);
            dif.dec_rs1_in = 5'($urandom % 4); dif.dec_rs2_in = 5'($urandom % 4);
            dif.dec_rd_in = 5'($urandom % 4);
            dif.dec_imm_in = $urandom; dif.dec_pc_in = $urandom;
            rs1_data = $urandom; rs2_data = $urandom;
            rs1_busy = 1'($urandom); rs2_busy = 1'($urandom);
            rs1_tag = 4'($urandom % 4); rs2_tag = 4'($urandom % 4);
            rob_full = ($urandom % 6) == 0; rob_free_tag = 4'($urandom);
            rob_q1_rdy = 1'($urandom); rob_q2_rdy = 1'($urandom);
            rob_q1_data = $urandom; rob_q2_data = $urandom;
            cdb_valid = 2'($urandom);
            cdb_tag = {4'($urandom % 4), 4'($urandom % 4)};
            cdb_data = {$urandom, $urandom};
            rs_full = ($urandom % 4) == 0; lsb_full = ($urandom % 4) == 0;
            tick(1);
        end
        idle(); tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
